// File: rtl/ps2_pkg.sv
// PS/2 scan-code constants and the default tracked-key table.
// Shared by the sequence parser and the key tracker top level.
package ps2_pkg;

  localparam int CODE_W = 9;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [CODE_W-1:0] KC_UP    = {1'b1, SC_UP};
  localparam logic [CODE_W-1:0] KC_DOWN  = {1'b1, SC_DOWN};
  localparam logic [CODE_W-1:0] KC_LEFT  = {1'b1, SC_LEFT};
  localparam logic [CODE_W-1:0] KC_RIGHT = {1'b1, SC_RIGHT};
  localparam logic [CODE_W-1:0] KC_A     = {1'b0, SC_A};
  localparam logic [CODE_W-1:0] KC_W     = {1'b0, SC_W};
  localparam logic [CODE_W-1:0] KC_S     = {1'b0, SC_S};
  localparam logic [CODE_W-1:0] KC_D     = {1'b0, SC_D};

  // Index 0 sits in the low bits: up, down, left, right, a, w, s, d.
  localparam logic [8*CODE_W-1:0] PS2_DEFAULT_KEYS = {
    KC_D, KC_S, KC_W, KC_A,
    KC_RIGHT, KC_LEFT, KC_DOWN, KC_UP
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } ps2_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_seq_parser.sv
// Folds E0/F0 prefixes into complete {ext, scan} codes.
// Outputs are combinational; the tracker registers them.
module ps2_seq_parser
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              data_en,
  input  logic              clear,
  output logic              code_valid,
  output logic [CODE_W-1:0] code,
  output logic              is_break,
  output logic              abort
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_ext, is_brk, pfx;
  logic            timeout;
  logic            st_ext, st_brk;

  assign is_ext  = (data == PS2_EXT);
  assign is_brk  = (data == PS2_BRK);
  assign pfx     = is_prefix(data);
  assign timeout = (state_q != IDLE) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (data_en) begin
      unique case (state_q)
        IDLE: begin
          if (is_ext)      state_d = GOT_E0;
          else if (is_brk) state_d = GOT_F0;
        end
        GOT_E0: begin
          if (is_brk)       state_d = GOT_E0F0;
          else if (!is_ext) state_d = IDLE;
        end
        GOT_F0: begin
          if (is_ext)       state_d = GOT_E0F0;
          else if (!is_brk) state_d = IDLE;
        end
        GOT_E0F0: begin
          if (!pfx) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  // Counter only measures silence while a prefix is pending.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || data_en || timeout || state_q == IDLE)
      cnt_d = '0;
  end

  always_comb begin
    st_ext = 1'b0;
    st_brk = 1'b0;
    unique case (state_q)
      IDLE:     ;
      GOT_E0:   st_ext = 1'b1;
      GOT_F0:   st_brk = 1'b1;
      GOT_E0F0: begin
        st_ext = 1'b1;
        st_brk = 1'b1;
      end
      default:  ;
    endcase
    code_valid = data_en && !clear && !pfx;
    code       = {st_ext, data};
    is_break   = st_brk;
    abort      = timeout && !data_en && !clear;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Table-driven PS/2 key tracker: held bitmap plus press/release
// pulses for any number of players from one byte stream.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  parameter logic [CODE_W*NUM_KEYS-1:0] KEY_CODES =
    PS2_DEFAULT_KEYS,
  parameter bit REPEAT_PRESS = 1'b0,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  input  logic                clear_all,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held,
  output logic [CODE_W-1:0]   last_code,
  output logic                unmapped,
  output logic                seq_abort
);

  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic              is_break;
  logic              abort;

  ps2_seq_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk        (CLOCK_50),
    .rst        (reset),
    .data       (received_data),
    .data_en    (received_data_en),
    .clear      (clear_all),
    .code_valid (code_valid),
    .code       (code),
    .is_break   (is_break),
    .abort      (abort)
  );

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic                any_held_q, any_held_d;
  logic [CODE_W-1:0]   last_code_q, last_code_d;
  logic                unmapped_q, unmapped_d;
  logic                seq_abort_q, seq_abort_d;

  // Duplicate table entries are legal, so every index is compared.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      match[i] = (code == KEY_CODES[CODE_W*i +: CODE_W]);
  end

  always_comb begin
    held_d      = held_q;
    press_d     = '0;
    release_d   = '0;
    unmapped_d  = 1'b0;
    last_code_d = last_code_q;
    seq_abort_d = abort;
    if (clear_all) begin
      release_d = held_q;
      held_d    = '0;
    end else if (code_valid) begin
      last_code_d = code;
      unmapped_d  = ~|match;
      if (is_break) begin
        held_d    = held_q & ~match;
        release_d = held_q & match;
      end else begin
        held_d  = held_q | match;
        press_d = REPEAT_PRESS ? match : (match & ~held_q);
      end
    end
    any_held_d = |held_d;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_held_q  <= 1'b0;
      last_code_q <= '0;
      unmapped_q  <= 1'b0;
      seq_abort_q <= 1'b0;
    end else begin
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_held_q  <= any_held_d;
      last_code_q <= last_code_d;
      unmapped_q  <= unmapped_d;
      seq_abort_q <= seq_abort_d;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_held    = any_held_q;
  assign last_code   = last_code_q;
  assign unmapped    = unmapped_q;
  assign seq_abort   = seq_abort_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: two instances (REPEAT_PRESS 0/1)
// checked every cycle against a prefix-flag model plus literals.
module tb_ps2_key_tracker;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] held  [2];
  logic [7:0] press [2];
  logic [7:0] rel   [2];
  logic [8:0] last  [2];
  logic       anyh  [2];
  logic       unm   [2];
  logic       abrt  [2];

  int checks   = 0;
  int failures = 0;

  // Model state: prefix flags, silence count and per-instance outputs.
  logic [8:0] tbl [8] = '{9'h175, 9'h172, 9'h16B, 9'h174,
                          9'h01C, 9'h01D, 9'h01B, 9'h023};
  bit         ext_s, brk_s;
  int         quiet;
  logic [7:0] e_held  [2];
  logic [7:0] e_press [2];
  logic [7:0] e_rel   [2];
  logic [8:0] e_last  [2];
  logic       e_unm   [2];
  logic       e_abrt  [2];

  int cnt0, cnt1;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS(8), .REPEAT_PRESS(1'b0), .TIMEOUT_CYCLES(T)
  ) dut0 (
    .CLOCK_50(clk), .reset(rst),
    .received_data(din), .received_data_en(en),
    .clear_all(clr),
    .key_held(held[0]), .key_press(press[0]),
    .key_release(rel[0]), .any_held(anyh[0]),
    .last_code(last[0]), .unmapped(unm[0]),
    .seq_abort(abrt[0])
  );

  ps2_key_tracker #(
    .NUM_KEYS(8), .REPEAT_PRESS(1'b1), .TIMEOUT_CYCLES(T)
  ) dut1 (
    .CLOCK_50(clk), .reset(rst),
    .received_data(din), .received_data_en(en),
    .clear_all(clr),
    .key_held(held[1]), .key_press(press[1]),
    .key_release(rel[1]), .any_held(anyh[1]),
    .last_code(last[1]), .unmapped(unm[1]),
    .seq_abort(abrt[1])
  );

  task automatic check(input string nm, input int m,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h",
               nm, m, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [8:0] c;
    bit         hit;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        e_held[m] = 0; e_press[m] = 0; e_rel[m] = 0;
        e_last[m] = 0; e_unm[m] = 0; e_abrt[m] = 0;
      end
      ext_s = 0; brk_s = 0; quiet = 0;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      e_press[m] = 0; e_rel[m] = 0; e_unm[m] = 0; e_abrt[m] = 0;
    end
    if (clr) begin
      for (int m = 0; m < 2; m++) begin
        e_rel[m]  = e_held[m];
        e_held[m] = 0;
      end
      ext_s = 0; brk_s = 0; quiet = 0;
    end else if (en) begin
      quiet = 0;
      if (din == 8'hE0) ext_s = 1;
      else if (din == 8'hF0) brk_s = 1;
      else begin
        c = {ext_s, din};
        for (int m = 0; m < 2; m++) begin
          hit = 0;
          for (int i = 0; i < 8; i++) begin
            if (c == tbl[i]) begin
              hit = 1;
              if (brk_s) begin
                if (e_held[m][i]) e_rel[m][i] = 1'b1;
                e_held[m][i] = 1'b0;
              end else begin
                if (!e_held[m][i] || m == 1) e_press[m][i] = 1'b1;
                e_held[m][i] = 1'b1;
              end
            end
          end
          e_last[m] = c;
          e_unm[m]  = !hit;
        end
        ext_s = 0; brk_s = 0;
      end
    end else if (ext_s || brk_s) begin
      quiet++;
      if (quiet == T) begin
        e_abrt[0] = 1; e_abrt[1] = 1;
        ext_s = 0; brk_s = 0; quiet = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check("held",    m, 32'(held[m]),  32'(e_held[m]));
      check("press",   m, 32'(press[m]), 32'(e_press[m]));
      check("release", m, 32'(rel[m]),   32'(e_rel[m]));
      check("any",     m, 32'(anyh[m]),  32'(|e_held[m]));
      check("last",    m, 32'(last[m]),  32'(e_last[m]));
      check("unmapped",m, 32'(unm[m]),   32'(e_unm[m]));
      check("abort",   m, 32'(abrt[m]),  32'(e_abrt[m]));
    end
  endtask

  task automatic send(input logic [7:0] b);
    din = b;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk or posedge rst);
        model_step();
      end
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst_held", 0, 32'(held[0]), 32'h00);
    check("rst_last", 0, 32'(last[0]), 32'h000);

    // Plain make / break of 'a'.
    send(8'h1C);
    check("a_held",  0, 32'(held[0]),  32'h10);
    check("a_press", 0, 32'(press[0]), 32'h10);
    check("a_last",  0, 32'(last[0]),  32'h01C);
    idle(1);
    check("a_press_end", 0, 32'(press[0]), 32'h00);
    send(8'hF0); send(8'h1C);
    check("a_brk_held", 0, 32'(held[0]), 32'h00);
    check("a_brk_rel",  0, 32'(rel[0]),  32'h10);

    // Extended up arrow, then bare 75.
    send(8'hE0); send(8'h75);
    check("up_held",  0, 32'(held[0]),  32'h01);
    check("up_press", 0, 32'(press[0]), 32'h01);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_brk_held", 0, 32'(held[0]), 32'h00);
    check("up_brk_rel",  0, 32'(rel[0]),  32'h01);
    send(8'h75);
    check("bare75_unm",  0, 32'(unm[0]),  32'h1);
    check("bare75_last", 0, 32'(last[0]), 32'h075);
    check("bare75_held", 0, 32'(held[0]), 32'h00);

    // Typematic repeats of 'w'.
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 3; k++) begin
      send(8'h1D);
      cnt0 += int'(press[0][5]);
      cnt1 += int'(press[1][5]);
      idle(1);
    end
    check("typ_rp0", 0, 32'(cnt0), 32'd1);
    check("typ_rp1", 1, 32'(cnt1), 32'd3);
    send(8'hF0); send(8'h1D);

    // F0 before E0 is tolerated; repeated E0 is absorbed.
    send(8'hE0); send(8'h6B);
    send(8'hF0); send(8'hE0); send(8'h6B);
    check("f0e0_rel", 0, 32'(rel[0]), 32'h04);
    send(8'hE0); send(8'hE0); send(8'h74);
    send(8'h23);
    check("two_held", 0, 32'(held[0]), 32'h88);

    // clear_all beats a simultaneous byte.
    din = 8'h1B; en = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1 en = 1'b0; clr = 1'b0;
    check("clr_held",  0, 32'(held[0]),  32'h00);
    check("clr_rel",   0, 32'(rel[0]),   32'h88);
    check("clr_press", 0, 32'(press[0]), 32'h00);
    check("clr_last",  0, 32'(last[0]),  32'h023);
    idle(1);

    // Timeout after a dangling E0.
    send(8'hE0);
    idle(T - 1);
    check("to_early", 0, 32'(abrt[0]), 32'h0);
    idle(1);
    check("to_fire", 0, 32'(abrt[0]), 32'h1);
    idle(1);
    check("to_pulse", 0, 32'(abrt[0]), 32'h0);
    send(8'h72);
    check("to_unm",  0, 32'(unm[0]),  32'h1);
    check("to_last", 0, 32'(last[0]), 32'h072);
    check("to_held", 0, 32'(held[0]), 32'h00);

    // A byte on the last allowed cycle still completes the code.
    send(8'hE0);
    idle(T - 1);
    send(8'h75);
    check("edge_press", 0, 32'(press[0]), 32'h01);
    check("edge_abort", 0, 32'(abrt[0]),  32'h0);
    send(8'hE0); send(8'hF0); send(8'h75);

    // Asynchronous reset mid-sequence.
    send(8'h1C);
    send(8'hE0);
    #2 rst = 1'b1;
    #1;
    check("arst_held", 0, 32'(held[0]), 32'h00);
    check("arst_any",  0, 32'(anyh[0]), 32'h0);
    check("arst_last", 0, 32'(last[0]), 32'h000);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    send(8'h6B);
    check("post_unm",  0, 32'(unm[0]),  32'h1);
    check("post_held", 0, 32'(held[0]), 32'h00);
    check("post_last", 0, 32'(last[0]), 32'h06B);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
